// File: rtl/instr_cache.sv
// rtl/instr_cache.sv - direct-mapped read-only instruction cache with 4-word block refill
// Optional hit/miss counters are compiled in with ICACHE_STATS_EN.
module instr_cache #(
  parameter int ADDR_W   = 10,
  parameter int NUM_SETS = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              READ,
  input  logic [ADDR_W-1:0] ADDRESS,
  output logic [31:0]       INSTRUCTION,
  output logic              BUSYWAIT,
  output logic              MEM_READ,
  output logic [ADDR_W-5:0] MEM_ADDRESS,
  input  logic [127:0]      MEM_READDATA,
  input  logic              MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       HIT_COUNT,
  output logic [31:0]       MISS_COUNT
`endif
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_W - 4 - IDX_W;

  typedef enum logic [1:0] {IDLE, MEM_RD, UPDATE} state_t;

  state_t              state, next_state;
  logic [NUM_SETS-1:0] valid;
  logic [TAG_W-1:0]    tag_store  [NUM_SETS];
  logic [127:0]        data_store [NUM_SETS];
  logic [ADDR_W-5:0]   miss_addr;
  logic [127:0]        fill;

  logic [1:0]          offset;
  logic [IDX_W-1:0]    index;
  logic [TAG_W-1:0]    tag;
  logic [IDX_W-1:0]    miss_idx;
  logic [TAG_W-1:0]    miss_tag;
  logic [127:0]        line;
  logic                hit;
  logic [1:0]          unused_byte_sel;

  assign offset          = ADDRESS[3:2];
  assign index           = ADDRESS[3+IDX_W:4];
  assign tag             = ADDRESS[ADDR_W-1:4+IDX_W];
  assign unused_byte_sel = ADDRESS[1:0];
  assign miss_idx        = miss_addr[IDX_W-1:0];
  assign miss_tag        = miss_addr[ADDR_W-5:IDX_W];
  assign line            = data_store[index];
  assign hit             = READ && valid[index] && (tag_store[index] == tag);

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (READ && !hit) next_state = MEM_RD;
      MEM_RD:  if (!MEM_BUSYWAIT) next_state = UPDATE;
      UPDATE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    BUSYWAIT    = 1'b0;
    INSTRUCTION = 32'h0;
    MEM_READ    = 1'b0;
    MEM_ADDRESS = '0;
    case (state)
      IDLE: begin
        BUSYWAIT = READ && !hit;
        if (hit) INSTRUCTION = line[{offset, 5'b0} +: 32];
      end
      MEM_RD: begin
        BUSYWAIT    = 1'b1;
        MEM_READ    = 1'b1;
        MEM_ADDRESS = miss_addr;
      end
      UPDATE:  BUSYWAIT = 1'b1;
      default: BUSYWAIT = 1'b0;
    endcase
  end

  // Tag and data arrays are deliberately left out of reset; only valid bits clear.
  always_ff @(posedge CLK) begin
    if (state == IDLE && READ && !hit) miss_addr <= {tag, index};
    if (state == MEM_RD && !MEM_BUSYWAIT) fill <= MEM_READDATA;
    if (!RESET && state == UPDATE) begin
      tag_store[miss_idx]  <= miss_tag;
      data_store[miss_idx] <= fill;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET)                valid <= '0;
    else if (state == UPDATE) valid[miss_idx] <= 1'b1;
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      HIT_COUNT  <= 32'h0;
      MISS_COUNT <= 32'h0;
    end else begin
      if (state == IDLE && hit)            HIT_COUNT  <= HIT_COUNT + 32'd1;
      if (state == IDLE && next_state == MEM_RD) MISS_COUNT <= MISS_COUNT + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_cache.sv
// tb/tb_instr_cache.sv - randomized self-checking bench for instr_cache against a set-level model
module tb_instr_cache;

  logic         CLK;
  logic         RESET;
  logic         READ;
  logic [9:0]   ADDRESS;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [5:0]   MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;
`ifdef ICACHE_STATS_EN
  logic [31:0]  HIT_COUNT;
  logic [31:0]  MISS_COUNT;
`endif

  instr_cache #(.ADDR_W(10), .NUM_SETS(8)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .READ(READ),
    .ADDRESS(ADDRESS),
    .INSTRUCTION(INSTRUCTION),
    .BUSYWAIT(BUSYWAIT),
    .MEM_READ(MEM_READ),
    .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_READDATA(MEM_READDATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT)
`ifdef ICACHE_STATS_EN
    ,
    .HIT_COUNT(HIT_COUNT),
    .MISS_COUNT(MISS_COUNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one valid flag and tag per set, plus hit/miss tallies.
  logic       m_valid [8];
  logic [2:0] m_tag   [8];
  int         m_hits;
  int         m_misses;

  function automatic logic [31:0] mem_word(input logic [5:0] blk, input logic [1:0] off);
    return {8'hA5, 2'b00, blk, 6'b0, off, blk, 2'b00, off};
  endfunction

  function automatic logic [127:0] mem_block(input logic [5:0] blk);
    return {mem_word(blk, 2'd3), mem_word(blk, 2'd2), mem_word(blk, 2'd1), mem_word(blk, 2'd0)};
  endfunction

  // Instruction memory: data only meaningful while not busy.
  assign MEM_READDATA = MEM_BUSYWAIT ? {4{32'hDEADBEEF}} : mem_block(MEM_ADDRESS);

  function automatic logic model_hit(input logic [9:0] a);
    return m_valid[a[6:4]] && (m_tag[a[6:4]] == a[9:7]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_stats(input string tag);
`ifdef ICACHE_STATS_EN
    check({tag, "_hits"}, HIT_COUNT, m_hits);
    check({tag, "_misses"}, MISS_COUNT, m_misses);
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_access(input logic [9:0] a, input int busy);
    logic [5:0] blk;
    logic [31:0] exp;
    blk = a[9:4];
    exp = mem_word(blk, a[3:2]);
    READ = 1'b1; ADDRESS = a; MEM_BUSYWAIT = 1'b1;
    #1;
    if (model_hit(a)) begin
      check("hit_busywait", BUSYWAIT, 1'b0);
      check("hit_instr", INSTRUCTION, exp);
      check("hit_mem_read", MEM_READ, 1'b0);
      m_hits++;
      step();
    end else begin
      check("miss_busywait", BUSYWAIT, 1'b1);
      check("miss_instr", INSTRUCTION, 32'h0);
      check("miss_mem_read_idle", MEM_READ, 1'b0);
      m_misses++;
      step();
      for (int i = 0; i < busy; i++) begin
        ADDRESS = 10'($urandom);
        #1;
        check("memrd_mem_read", MEM_READ, 1'b1);
        check("memrd_mem_addr", MEM_ADDRESS, blk);
        check("memrd_busywait", BUSYWAIT, 1'b1);
        check("memrd_instr", INSTRUCTION, 32'h0);
        step();
      end
      MEM_BUSYWAIT = 1'b0;
      #1;
      check("memrd_last_mem_read", MEM_READ, 1'b1);
      check("memrd_last_mem_addr", MEM_ADDRESS, blk);
      step();
      MEM_BUSYWAIT = 1'b1;
      #1;
      check("update_busywait", BUSYWAIT, 1'b1);
      check("update_mem_read", MEM_READ, 1'b0);
      check("update_mem_addr", MEM_ADDRESS, 6'h0);
      check("update_instr", INSTRUCTION, 32'h0);
      step();
      m_valid[a[6:4]] = 1'b1;
      m_tag[a[6:4]]   = a[9:7];
      ADDRESS = a;
      #1;
      check("fill_busywait", BUSYWAIT, 1'b0);
      check("fill_instr", INSTRUCTION, exp);
      m_hits++;
      step();
    end
  endtask

  task automatic idle_cycle(input logic [9:0] a);
    READ = 1'b0; ADDRESS = a; MEM_BUSYWAIT = 1'b1;
    #1;
    check("idle_busywait", BUSYWAIT, 1'b0);
    check("idle_instr", INSTRUCTION, 32'h0);
    check("idle_mem_read", MEM_READ, 1'b0);
    step();
  endtask

  // Miss on a, reset during the second MEM_RD cycle while memory drops busy late.
  task automatic reset_mid_miss(input logic [9:0] a);
    READ = 1'b1; ADDRESS = a; MEM_BUSYWAIT = 1'b1;
    #1;
    check("rst_miss_busywait", BUSYWAIT, 1'b1);
    m_misses++;
    step();
    #1;
    check("rst_memrd1_mem_read", MEM_READ, 1'b1);
    step();
    RESET = 1'b1; MEM_BUSYWAIT = 1'b0;
    #1;
    check("rst_memrd2_mem_read", MEM_READ, 1'b1);
    step();
    RESET = 1'b0; READ = 1'b0; MEM_BUSYWAIT = 1'b0;
    model_reset();
    #1;
    check("rst_after_mem_read", MEM_READ, 1'b0);
    check("rst_after_mem_addr", MEM_ADDRESS, 6'h0);
    check("rst_after_busywait", BUSYWAIT, 1'b0);
    check_stats("rst_after");
    step();
    MEM_BUSYWAIT = 1'b1;
    #1;
    check("rst_settle_mem_read", MEM_READ, 1'b0);
    step();
  endtask

  logic [9:0] ra;
  int         rr;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; READ = 1'b0; ADDRESS = 10'h0; MEM_BUSYWAIT = 1'b1;
    model_reset();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("reset_busywait", BUSYWAIT, 1'b0);
    check("reset_instr", INSTRUCTION, 32'h0);
    check("reset_mem_read", MEM_READ, 1'b0);
    check("reset_mem_addr", MEM_ADDRESS, 6'h0);
    check_stats("reset");
    step();

    // Cold miss with a 5-cycle memory stall, then sequential hits.
    do_access(10'h000, 5);
    do_access(10'h004, 0);
    do_access(10'h008, 0);
    do_access(10'h00C, 0);
    check_stats("cold_plus_hits");

    // Conflict eviction on set 0, then re-fetch of the evicted block.
    do_access(10'h080, 2);
    do_access(10'h000, 1);

    // Independent sets coexist.
    do_access(10'h010, 0);
    for (int i = 0; i < 4; i++) begin
      do_access(10'h000, 0);
      do_access(10'h014, 0);
    end
    idle_cycle(10'h3FC);

    reset_mid_miss(10'h300);
    do_access(10'h000, 1);

    for (int n = 0; n < 250; n++) begin
      rr = $urandom_range(0, 19);
      ra = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      if (rr == 0)                         idle_cycle(ra);
      else if (rr == 1 && !model_hit(ra))  reset_mid_miss(ra);
      else                                 do_access(ra, $urandom_range(0, 4));
    end
    check_stats("random_end");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_cache.md
Name: instr_cache

Overview:
- Direct-mapped, read-only instruction cache between the program counter and the instruction memory.
- Takes the fetch address from the PC stage and returns the 32-bit instruction on a hit in the same cycle.
- On a miss it asserts BUSYWAIT to stall the PC, fetches a 4-word block from instruction memory over a busywait handshake, installs the block, then serves the hit.

Parameters:
- ADDR_W, 10: byte-address width used from the PC. Bits [1:0] are ignored; bits [3:2] select the word within the block.
- NUM_SETS, 8: number of cache lines. Must be a power of two.
  - IDX_W = log2(NUM_SETS).
  - TAG_W = ADDR_W - 4 - IDX_W.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  reset, synchronous, active-high.
- READ  in  1  fetch request; high when ADDRESS holds a valid PC.
- ADDRESS  in  ADDR_W  byte address from the PC stage.
- INSTRUCTION  out  32  selected instruction word.
- BUSYWAIT  out  1  stall to the PC stage.
- MEM_READ  out  1  block read request to instruction memory.
- MEM_ADDRESS  out  ADDR_W-4  block address to memory, equal to {tag, index}.
- MEM_READDATA  in  128  block returned by memory; word 0 is in bits [31:0].
- MEM_BUSYWAIT  in  1  memory busy; data is valid in the cycle it is low while MEM_READ is high.

Behaviour:
- Address split:
  - offset = ADDRESS[3:2]
  - index = ADDRESS[3+IDX_W:4]
  - tag = ADDRESS[ADDR_W-1:4+IDX_W]
- Storage per line: valid bit, TAG_W tag, 128-bit block. There is no dirty bit; the cache never writes back.
- hit = READ && valid[index] && (tag_store[index] == tag). This is combinational.
- INSTRUCTION = word[offset] of line[index] when hit and state == IDLE, else 32'h0.
- BUSYWAIT is combinational:
  - 1 when READ && !hit in IDLE.
  - 1 throughout MEM_RD and UPDATE.
  - 0 otherwise.
- FSM states:
  - IDLE: on a posedge with READ && !hit, latch {tag, index} into miss_addr and go to MEM_RD. Otherwise stay.
  - MEM_RD: MEM_READ=1, MEM_ADDRESS=miss_addr. Stay while MEM_BUSYWAIT=1. On a posedge with MEM_BUSYWAIT=0, capture MEM_READDATA into the fill register and go to UPDATE.
  - UPDATE: on the next posedge, write the block, set tag=miss_addr tag and valid=1 at miss_addr index, then go to IDLE. The following IDLE cycle is a hit.
- Outside MEM_RD, MEM_READ=0 and MEM_ADDRESS=0.
- Miss latency: from the miss being detected to the hit cycle = 2 + (cycles MEM_BUSYWAIT stays high) + 1 posedges.
- A miss uses the latched miss_addr. A change in ADDRESS during a miss does not alter the fetch.
- On return to IDLE, hit is re-evaluated against the current ADDRESS. If that address misses, a new miss starts.
- READ low in IDLE gives BUSYWAIT=0, INSTRUCTION=0, no state change.
- A conflicting tag on a valid line replaces that line. Other lines are untouched.
- Reset values:
  - all valid bits 0, state IDLE
  - MEM_READ=0, MEM_ADDRESS=0, BUSYWAIT=0 (when READ=0), INSTRUCTION=0
  - tag and data arrays are not cleared
- Reset mid-miss (in MEM_RD or UPDATE): go to IDLE at that posedge, the line is not written, and MEM_READ drops in the cycle after reset is sampled. A late MEM_BUSYWAIT drop is ignored.
- RESET has priority over every other transition.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined: adds outputs HIT_COUNT[31:0] and MISS_COUNT[31:0].
  - Both reset to 0.
  - HIT_COUNT increments on each posedge in IDLE with hit.
  - MISS_COUNT increments on each IDLE->MEM_RD transition.
  - Both counters wrap modulo 2^32.
- Undefined: these ports and counters do not exist. Core behaviour is identical in both cases.

Test Plan:
- Cold miss: reset; READ=1, ADDRESS=0x000; memory holds MEM_BUSYWAIT=1 for 5 cycles, then returns 128'h...0C_...08_...04_...00.
  - BUSYWAIT=1 immediately.
  - MEM_READ=1 with MEM_ADDRESS=0.
  - After UPDATE, BUSYWAIT=0 and INSTRUCTION=word0.
- Sequential hits: after the cold miss, ADDRESS 0x004, 0x008, 0x00C on consecutive cycles -> BUSYWAIT=0 each cycle, INSTRUCTION = words 1, 2, 3, no MEM_READ.
- Conflict eviction: ADDRESS=0x080 (same index 0, tag 1) -> miss with MEM_ADDRESS=0x08. A later ADDRESS=0x000 misses again with MEM_ADDRESS=0x00.
- Independent sets: fill 0x010 (index 1), then access 0x000 and 0x010 alternately -> no further misses.
- Reset mid-miss: assert RESET on the 2nd MEM_RD cycle -> state IDLE, MEM_READ=0 on the next cycle. The next read of 0x000 misses again.
- Stats (ICACHE_STATS_EN): cold miss + 3 hits -> MISS_COUNT=1, HIT_COUNT=4 (including the post-fill hit). RESET -> both 0.
